// File: rtl/mem_copy_dma.sv
// Byte-wise memory-to-memory copy engine.
// Each byte is read, held for READ_LAT cycles while the memory answers,
// then written to the destination. All outputs are registered; the
// data-register role is played by WriteData, which captures ReadData on
// the final WAIT edge and is then driven during the WR cycle.
module mem_copy_dma #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] count,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [7:0] Address,
    output logic [7:0] WriteData,
    input  logic [7:0] ReadData
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} stateT;

    stateT      state;
    logic [7:0] srcQ;
    logic [7:0] dstQ;
    logic [7:0] lenQ;
    logic [1:0] waitCnt;
    logic [7:0] nextCount;

    assign nextCount = count + 8'd1;

    // Copy sequencer: state, captured parameters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            srcQ      <= 8'h00;
            dstQ      <= 8'h00;
            lenQ      <= 8'h00;
            waitCnt   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= 8'h00;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            Address   <= 8'h00;
            WriteData <= 8'h00;
        end else begin
            // Strobes and done are single-cycle; only the branch that
            // enters RD/WR/DONE raises them again.
            done     <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        srcQ  <= src;
                        dstQ  <= dst;
                        lenQ  <= len;
                        count <= 8'h00;
                        if (len != 8'h00) begin
                            state   <= RD;
                            busy    <= 1'b1;
                            MemRead <= 1'b1;
                            Address <= src;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= WAIT;
                        waitCnt <= 2'(READ_LAT - 1);
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (waitCnt == 2'd0) begin
                        state     <= WR;
                        MemWrite  <= 1'b1;
                        Address   <= dstQ + count;
                        WriteData <= ReadData;
                    end else begin
                        waitCnt <= waitCnt - 2'd1;
                    end
                end
                WR: begin
                    // The write strobe is already on the bus this cycle,
                    // so the byte counts even when abort arrives with it.
                    count <= nextCount;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (nextCount == lenQ) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= RD;
                        MemRead <= 1'b1;
                        Address <= srcQ + nextCount;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
- REQ-001: Parameter READ_LAT, default 1, is the number of cycles after a MemRead cycle before ReadData is valid; legal range 1-4.
- REQ-002: clk  input  1  single clock; all state updates on the rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-low (asserted when 0).
- REQ-004: start  input  1  one-cycle copy request; sampled only in IDLE.
- REQ-005: src  input  8  source base byte address, captured on accepted start.
- REQ-006: dst  input  8  destination base byte address, captured on accepted start.
- REQ-007: len  input  8  byte count, captured on accepted start; 0 means no transfer.
- REQ-008: abort  input  1  cancels an active copy.
- REQ-009: busy  output  1  high from the cycle after an accepted start until return to IDLE.
- REQ-010: done  output  1  one-cycle pulse on normal completion.
- REQ-011: count  output  8  bytes written so far in the current or last copy.
- REQ-012: MemRead  output  1  data memory read strobe.
- REQ-013: MemWrite  output  1  data memory write strobe.
- REQ-014: Address  output  8  data memory byte address.
- REQ-015: WriteData  output  8  data memory write data.
- REQ-016: ReadData  input  8  data memory read data.

Function
- REQ-017: The FSM SHALL have exactly these states: IDLE, RD, WAIT, WR, DONE.
- REQ-018: IDLE with start=1 and len!=0: capture src/dst/len, clear count, go to RD.
- REQ-019: IDLE with start=1 and len=0: capture inputs, clear count, go to DONE; no memory strobe is issued.
- REQ-020: RD, one cycle: MemRead=1, Address=src_q+count (mod 256); next state WAIT.
- REQ-021: WAIT lasts exactly READ_LAT cycles with both strobes low; ReadData is captured into a data register on the last WAIT edge; next state WR.
- REQ-022: WR, one cycle: MemWrite=1, Address=dst_q+count (mod 256), WriteData=captured byte; count increments at the WR edge.
- REQ-023: After WR, go to DONE if the incremented count equals len_q, else go to RD.
- REQ-024: DONE, one cycle: done=1, busy=0, strobes low; next state IDLE; count holds its final value.
- REQ-025: MemRead and MemWrite SHALL never both be 1 in the same cycle; both SHALL be 0 in IDLE, WAIT and DONE.
- REQ-026: Per-byte cost is READ_LAT+2 cycles; a copy of N>0 bytes takes N*(READ_LAT+2) cycles from first RD to DONE.
- REQ-027: Address arithmetic is 8-bit and wraps 0xFF->0x00 with no error.
- REQ-028: Copy order is strictly ascending by offset; overlapping regions produce exactly the result of that sequential order.
- REQ-029: start while not in IDLE SHALL be ignored, and captured parameters are unchanged.
- REQ-030: abort=1 in RD, WAIT or WR: go to IDLE at the next edge, with strobes low from that edge and no done pulse; a WR cycle coinciding with abort still completes its write and counts it.
- REQ-031: abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE SHALL accept the start.
- REQ-032: Address and WriteData SHALL hold their last driven values when no strobe is active.

Reset
- REQ-033: While rst=0, regardless of clk: state=IDLE; busy=0, done=0, count=0, MemRead=0, MemWrite=0, Address=0x00, WriteData=0x00; internal src/dst/len/data registers=0.
- REQ-034: Reset asserted mid-copy SHALL abandon the copy immediately, and no further strobe or done is produced after release until a new start.
- REQ-035: The first start SHALL be accepted on the first rising edge where rst=1.

Verification
- REQ-036: READ_LAT=1, mem[0x10..0x13]={A1,B2,C3,D4}, start src=0x10 dst=0x80 len=4 -> mem[0x80..0x83]={A1,B2,C3,D4}, done one cycle at 12 cycles after first RD, count=4.
- REQ-037: start len=0 -> done on the cycle after start, no MemRead/MemWrite ever high, count=0.
- REQ-038: src=0xFE dst=0x01 len=3, mem[0xFE,0xFF,0x00]={11,22,33} -> reads at 0xFE,0xFF,0x00; writes 11,22,33 to 0x01,0x02,0x03 in order.
- REQ-039: len=8 copy, abort asserted during the 3rd WR -> 3 bytes written, count=3, no done, IDLE next cycle; a second start during busy is ignored.
- REQ-040: rst=0 asynchronously mid-WAIT of a len=5 copy -> all outputs at reset values before the next clk edge, and no write occurs after release.
- REQ-041: READ_LAT=3, len=2 -> exactly 3 WAIT cycles per byte, done 10 cycles after first RD, MemRead/MemWrite never both high.
